// File: rtl/mem_share_control_wrapper_if.sv
// Bus between the access-request generator / register loader and the memory-share
// control block; the control block uses the slave modport.
interface mem_share_control_wrapper_if #(
    parameter int SHARE_GROUP_SIZE        = 5,
    parameter int RQST_ADDR_BITWIDTH      = 2,
    parameter int RQST_MODE_BITWIDTH      = 2,
    parameter int L1PA_REGFILE_ADDR_WIDTH = 4,
    parameter int L1PA_SHIFT_BITWIDTH     = 3,
    parameter int L1PA_REGFILE_PAGE_WIDTH = 4
);
    logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] rqst_addr_i;
    logic [RQST_MODE_BITWIDTH-1:0]                  modeSet_i;
    logic [L1PA_SHIFT_BITWIDTH-1:0]                 l1pa_shift_o;
    logic                                           isGtr_o;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]             regType0_waddr_i;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0]             regType0_wdata_i;
    logic                                           regType0_we_i;

    modport master (
        output rqst_addr_i, modeSet_i, regType0_waddr_i, regType0_wdata_i, regType0_we_i,
        input  l1pa_shift_o, isGtr_o
    );

    modport slave (
        input  rqst_addr_i, modeSet_i, regType0_waddr_i, regType0_wdata_i, regType0_we_i,
        output l1pa_shift_o, isGtr_o
    );
endinterface

// File: rtl/mem_share_control_wrapper.sv
// L1PA shift-pattern register file plus sequencer for one memory share group.
// Optional macro MEMSHARE_REGFILE_WRITE_PROTECT_EN blocks register-file writes while in RUN.
//
// state | meaning
// IDLE  | outputs zero; waits for a non-zero modeSet_i, latches offset and base pointer
// RUN   | emits one shift per cycle from regfile[ptr] until the gtr flag or ptr[1:0]==3
module mem_share_control_wrapper #(
    parameter int SHARE_GROUP_SIZE        = 5,
    parameter int RQST_ADDR_BITWIDTH      = 2,
    parameter int RQST_MODE_BITWIDTH      = 2,
    parameter int L1PA_REGFILE_PAGE_NUM   = 16,
    parameter int L1PA_REGFILE_ADDR_WIDTH = 4,
    parameter int L1PA_SHIFT_BITWIDTH     = 3,
    parameter int L1PA_REGFILE_PAGE_WIDTH = 4
) (
    input logic                        sys_clk,
    input logic                        rstn,
    mem_share_control_wrapper_if.slave bus
);
    localparam int SUM_W = $clog2(SHARE_GROUP_SIZE * ((1 << RQST_ADDR_BITWIDTH) - 1) + 1);
    localparam int ADD_W = L1PA_SHIFT_BITWIDTH + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0]   r_regfile [L1PA_REGFILE_PAGE_NUM];
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]   r_ptr;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       r_offset;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       w_offset_nxt;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       w_offset_new;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       r_shift;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       w_shift_nxt;
    logic [L1PA_SHIFT_BITWIDTH-1:0]       w_shift_mod;
    logic                                 r_gtr;
    logic                                 w_gtr_nxt;
    logic [SUM_W-1:0]                     w_addr_sum;
    logic [ADD_W-1:0]                     w_shift_sum;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0]   w_entry;
    logic                                 w_last;
    logic                                 w_we;

    always_comb begin
        w_addr_sum = '0;
        for (int k = 0; k < SHARE_GROUP_SIZE; k++) begin
            w_addr_sum = w_addr_sum
                       + SUM_W'(bus.rqst_addr_i[k*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH]);
        end
    end

    assign w_offset_new = L1PA_SHIFT_BITWIDTH'(w_addr_sum % SUM_W'(SHARE_GROUP_SIZE));

    // Read is combinational on the old array contents, so a same-cycle write is seen next cycle.
    assign w_entry     = r_regfile[r_ptr];
    assign w_shift_sum = ADD_W'(w_entry[L1PA_SHIFT_BITWIDTH-1:0]) + ADD_W'(r_offset);
    assign w_shift_mod = L1PA_SHIFT_BITWIDTH'(w_shift_sum % ADD_W'(SHARE_GROUP_SIZE));
    assign w_last      = (r_ptr[1:0] == 2'b11) | w_entry[L1PA_REGFILE_PAGE_WIDTH-1];

`ifdef MEMSHARE_REGFILE_WRITE_PROTECT_EN
    assign w_we = bus.regType0_we_i & (r_state != RUN);
`else
    assign w_we = bus.regType0_we_i;
`endif

    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            r_regfile[bus.regType0_waddr_i] <= bus.regType0_wdata_i;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_offset_nxt = r_offset;
        w_shift_nxt  = '0;
        w_gtr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.modeSet_i != '0) begin
                    w_state_nxt  = RUN;
                    w_ptr_nxt    = L1PA_REGFILE_ADDR_WIDTH'({bus.modeSet_i, 2'b00});
                    w_offset_nxt = w_offset_new;
                end
            end
            RUN: begin
                w_shift_nxt = w_shift_mod;
                w_gtr_nxt   = w_last;
                if (w_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // rstn is active-high despite its name
    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_offset <= '0;
            r_shift  <= '0;
            r_gtr    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_offset <= w_offset_nxt;
            r_shift  <= w_shift_nxt;
            r_gtr    <= w_gtr_nxt;
        end
    end

    assign bus.l1pa_shift_o = r_shift;
    assign bus.isGtr_o      = r_gtr;
endmodule

// File: tb/tb_mem_share_control_wrapper.sv
// Directed bench for mem_share_control_wrapper: loads patterns during reset, walks
// sequences, checks offset, wrap, reset abort, back-to-back and same-cycle write.
module tb_mem_share_control_wrapper;
    logic sys_clk;
    logic rstn;
    int   n_checks;
    int   n_pass;

    mem_share_control_wrapper_if bus ();

    mem_share_control_wrapper dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic out(input string tag, input int sh, input int g);
        step();
        chk({tag, "_shift"}, 32'(bus.l1pa_shift_o), 32'(sh));
        chk({tag, "_gtr"}, 32'(bus.isGtr_o), 32'(g));
    endtask

    task automatic start(input logic [1:0] mode, input logic [9:0] lanes);
        bus.rqst_addr_i = lanes;
        bus.modeSet_i   = mode;
        step();
        bus.modeSet_i   = 2'd0;
    endtask

    task automatic wr(input int addr, input logic [3:0] data);
        bus.regType0_we_i    = 1'b1;
        bus.regType0_waddr_i = 4'(addr);
        bus.regType0_wdata_i = data;
        step();
        bus.regType0_we_i    = 1'b0;
    endtask

    initial begin
        int exp9;
        n_checks             = 0;
        n_pass               = 0;
        rstn                 = 1'b1;
        bus.rqst_addr_i      = '0;
        bus.modeSet_i        = '0;
        bus.regType0_we_i    = 1'b0;
        bus.regType0_waddr_i = '0;
        bus.regType0_wdata_i = '0;
        step();

        // Load entry i <= i while reset is held
        for (int i = 0; i < 16; i++) begin
            wr(i, 4'(i));
        end
        chk("rst_shift", 32'(bus.l1pa_shift_o), 32'd0);
        chk("rst_gtr", 32'(bus.isGtr_o), 32'd0);
        rstn = 1'b0;
        out("idle", 0, 0);

        // Mode 1, offset 0: entries 4..7 -> 4,0,1,2, forced last at ptr 7
        start(2'd1, 10'd0);
        out("m1_c0", 4, 0);
        out("m1_c1", 0, 0);
        out("m1_c2", 1, 0);
        out("m1_c3", 2, 1);
        out("m1_after0", 0, 0);
        out("m1_after1", 0, 0);

        // Mode 2, offset 3, held high: single-entry sequence repeats after one idle cycle
        bus.rqst_addr_i = 10'b00_00_01_01_01;
        bus.modeSet_i   = 2'd2;
        step();
        out("m2_a", 3, 1);
        out("m2_gap", 0, 0);
        bus.modeSet_i   = 2'd0;
        out("m2_b", 3, 1);
        out("m2_after", 0, 0);

        // Mode 3, lanes all 3 (sum 15, offset 0)
        wr(12, 4'b0010);
        wr(13, 4'b1100);
        start(2'd3, 10'h3FF);
        out("m3_c0", 2, 0);
        out("m3_c1", 4, 1);
        out("m3_after", 0, 0);

        // Reset during the second output of mode 1, then restart
        start(2'd1, 10'd0);
        out("ab_c0", 4, 0);
        out("ab_c1", 0, 0);
        rstn = 1'b1;
        out("ab_rst", 0, 0);
        rstn = 1'b0;
        out("ab_idle", 0, 0);
        start(2'd1, 10'd0);
        out("rs_c0", 4, 0);
        out("rs_c1", 0, 0);
        out("rs_c2", 1, 0);
        out("rs_c3", 2, 1);
        out("rs_after", 0, 0);

        // Same-cycle write of entry 9 while it is being read
        wr(8, 4'b0000);
        start(2'd2, 10'd0);
        out("sw_c0", 0, 0);
        bus.regType0_we_i    = 1'b1;
        bus.regType0_waddr_i = 4'd9;
        bus.regType0_wdata_i = 4'b1011;
        out("sw_old", 1, 1);
        bus.regType0_we_i    = 1'b0;
        out("sw_after", 0, 0);
`ifdef MEMSHARE_REGFILE_WRITE_PROTECT_EN
        exp9 = 1;
`else
        exp9 = 3;
`endif
        start(2'd2, 10'd0);
        out("sw2_c0", 0, 0);
        out("sw2_new", exp9, 1);
        out("sw2_after", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_share_control_wrapper.md
Name: mem_share_control_wrapper

Overview:
Memory-share control block for one share group of SHARE_GROUP_SIZE requestors. It holds an L1PA shift-pattern register file (SPR entries) that is loaded through a write port. On a mode request, a sequencer walks one shift-pattern sequence and drives the per-cycle L1PA shift amount. It also flags the last pattern of the sequence (isGtr). The block sits between the access-request generator and the L1PA permutation network.

Parameters:
- SHARE_GROUP_SIZE, 5, number of requestor lanes sharing the memory.
- RQST_ADDR_BITWIDTH, 2, address width per requestor lane.
- RQST_MODE_BITWIDTH, 2, width of modeSet_i.
- L1PA_REGFILE_PAGE_NUM, 16, number of register-file entries.
- L1PA_REGFILE_ADDR_WIDTH, 4, equals clog2(L1PA_REGFILE_PAGE_NUM).
- L1PA_SHIFT_BITWIDTH, 3, equals clog2(SHARE_GROUP_SIZE).
- L1PA_REGFILE_PAGE_WIDTH, 4, equals L1PA_SHIFT_BITWIDTH+1.

Ports:
- sys_clk  in  1  single clock; all logic is on its rising edge.
- rstn  in  1  synchronous, active-high reset (1 = reset), despite the name.
- rqst_addr_i  in  RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE  packed lane addresses; lane k is bits [k*W +: W].
- modeSet_i  in  RQST_MODE_BITWIDTH  0 = idle; 1..3 selects a shift sequence.
- l1pa_shift_o  out  L1PA_SHIFT_BITWIDTH  shift control to the L1PA.
- isGtr_o  out  1  1 = current output is the last pattern of the sequence.
- regType0_waddr_i  in  L1PA_REGFILE_ADDR_WIDTH  register-file write address.
- regType0_wdata_i  in  L1PA_REGFILE_PAGE_WIDTH  write data: bit[MSB] = gtr flag, bits[MSB-1:0] = shift.
- regType0_we_i  in  1  write enable.

Behaviour:
Register file:
- L1PA_REGFILE_PAGE_NUM x PAGE_WIDTH; synchronous write on regType0_we_i.
- Contents are not reset; writes are accepted while rstn=1.
- Read is combinational on the internal pointer. Read and write to the same address in the same cycle returns the old data; the new data is visible next cycle.

Reset:
- FSM goes to IDLE; l1pa_shift_o=0, isGtr_o=0; pointer, latched mode and offset = 0.
- Reset mid-sequence aborts it at that edge.

FSM state IDLE:
- Outputs 0.
- If modeSet_i!=0 at an edge:
  - latch offset = (sum of all lane addresses) mod SHARE_GROUP_SIZE, computed with enough width (max 15 at defaults);
  - ptr = {modeSet_i, 2'b00};
  - go to RUN.

FSM state RUN, each edge:
- Read entry = regfile[ptr]. If ptr[1:0]==3, force last = 1; otherwise last = entry.gtr.
- l1pa_shift_o <= (entry.shift + offset) mod SHARE_GROUP_SIZE. Shift values >= SHARE_GROUP_SIZE are also reduced.
- isGtr_o <= last.
- If last: go to IDLE, with outputs cleared on the following edge. Else ptr <= ptr+1.
- modeSet_i and rqst_addr_i are ignored while in RUN. A new request is only sampled in IDLE.

Timing and boundaries:
- Latency: mode sampled at edge N; first output valid after edge N+1.
- A sequence is at most 4 outputs. The isGtr_o pulse lasts exactly one cycle.
- Back-to-back: one IDLE cycle with zero outputs separates sequences.
- Mode 0 base entries 0..3 are unreachable by the sequencer but are still writable.

Optional Feature:
MEMSHARE_REGFILE_WRITE_PROTECT_EN:
- Defined: regType0_we_i is ignored while the FSM is in RUN, so the active sequence cannot be corrupted.
- Undefined: writes are always accepted, including during RUN and during reset.

Test Plan:
1. With rstn held 1, write entry i <= data i for i=0..15 -> after reset, each sequence reads back the expected entries, proving writes during reset succeed.
2. With entries loaded as in 1, all lanes 0, modeSet_i=1 for one cycle -> l1pa_shift_o = 4,0,1,2 on 4 consecutive cycles; isGtr_o=1 only on the 4th (forced wrap at ptr 7); outputs 0 afterwards.
3. Same load, lanes {1,1,1,0,0} (offset 3), modeSet_i=2 -> entry 8 (gtr=1, shift 0) gives one cycle of shift=3, isGtr_o=1, then IDLE.
4. Write entry 12 = 4'b0010, entry 13 = 4'b1100; lanes all 3 (sum 15, offset 0); modeSet_i=3 -> shift 2 then shift 4 with isGtr_o=1.
5. Assert rstn during the 2nd cycle of scenario 2 -> outputs 0 after the next edge; a new modeSet_i=1 restarts from shift 4.
6. Same-cycle write of entry 9 while ptr=9 is being read -> the old value is used; the new value appears on the next sequence. With MEMSHARE_REGFILE_WRITE_PROTECT_EN defined, the write is dropped.
